// File: rtl/ev22_pkg.sv
// Shared types and constants for the EV22 instruction sequencer.
package ev22_pkg;

  localparam int PC_W = 12;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2,
    S_EXEC   = 2'd3
  } seq_state_t;

  localparam logic [4:0] GRP0 = 5'b10000;
  localparam logic [4:0] GRP1 = 5'b01000;
  localparam logic [4:0] GRP2 = 5'b00100;
  localparam logic [4:0] GRP3 = 5'b00010;
  localparam logic [4:0] GRP4 = 5'b00001;

  localparam logic [7:0] OP_JMP = 8'd0;
  localparam logic [7:0] OP_JZE = 8'd1;
  localparam logic [7:0] OP_JNE = 8'd2;
  localparam logic [7:0] OP_JCY = 8'd3;
  localparam logic [7:0] OP_RET = 8'd4;
  localparam logic [7:0] OP_BSR = 8'd5;

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address LIFO. The fill pointer saturates at 0 and DEPTH;
// pushes when full and pops when empty are ignored (the caller flags them).
module ret_stack
  import ev22_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = PC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]   ptr_q, ptr_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] top_idx;

  assign full    = (ptr_q == (AW+1)'(DEPTH));
  assign empty   = (ptr_q == '0);
  // When full the low pointer bits are zero, so the decrement lands on DEPTH-1.
  assign top_idx = ptr_q[AW-1:0] - AW'(1);
  assign dout    = mem_q[top_idx];

  always_comb begin
    ptr_d = ptr_q;
    if (push && !full) begin
      ptr_d = ptr_q + (AW+1)'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/seq_ctrl.sv
// EV22 instruction sequencer: PC, instruction fetch handshake, decode wait,
// execute gating and group-0 control-flow resolution with a return stack.
//   state    | meaning
//   S_IDLE   | parked, waiting for run
//   S_FETCH  | pm_rd high, waiting for pm_valid
//   S_DECODE | decoder registered-latency cycle
//   S_EXEC   | exec_en high until dp_busy drops, then PC update
module seq_ctrl
  import ev22_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = 12'h000,
  parameter int              STACK_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [PC_W-1:0] pm_addr,
  output logic            pm_rd,
  input  logic [23:0]     pm_data,
  input  logic            pm_valid,
  output logic [23:0]     ir,
  output logic            exec_en,
  input  logic            dp_busy,
  input  logic            flag_z,
  input  logic            flag_cy,
  output logic            stk_err,
  output logic [1:0]      state_o
);

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, target, stk_dout;
  logic [23:0]     ir_q, ir_d;
  logic            err_q, err_d;
  logic            push, pop, stk_full, stk_empty, done, is_g0;
  logic [7:0]      op;

  assign pc_inc = pc_q + PC_W'(1);
  assign target = ir_q[11:0];
  assign op     = ir_q[19:12];
  assign is_g0  = (ir_q[23:19] == GRP0);
  assign done   = (state_q == S_EXEC) && !dp_busy;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pm_rd   = 1'b0;
    exec_en = 1'b0;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        pm_rd = 1'b1;
        if (pm_valid) begin
          ir_d    = pm_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        exec_en = 1'b1;
        if (!dp_busy) state_d = run ? S_FETCH : S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Flags are only looked at in the final EXEC cycle.
  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    push  = 1'b0;
    pop   = 1'b0;
    if (done) begin
      pc_d = pc_inc;
      if (is_g0) begin
        case (op)
          OP_JMP: pc_d = target;
          OP_JZE: if (flag_z)  pc_d = target;
          OP_JNE: if (!flag_z) pc_d = target;
          OP_JCY: if (flag_cy) pc_d = target;
          OP_RET: begin
            if (stk_empty) begin
              err_d = 1'b1;
            end else begin
              pop  = 1'b1;
              pc_d = stk_dout;
            end
          end
          OP_BSR: begin
            pc_d = target;
            if (stk_full) err_d = 1'b1;
            else          push  = 1'b1;
          end
          default: pc_d = pc_inc;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  ret_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign pm_addr = pc_q;
  assign ir      = ir_q;
  assign stk_err = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: vector table, directed multi-cycle cases,
// and randomized programs against an instruction-level reference model.
module tb_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, run, pm_rd, pm_valid, exec_en, dp_busy, flag_z, flag_cy, stk_err;
  logic [11:0] pm_addr;
  logic [23:0] pm_data, ir;
  logic [1:0]  state_o;

  int n_chk  = 0;
  int n_pass = 0;

  logic [23:0] mem [4096];

  logic [11:0] m_pc;
  logic [11:0] m_stk [$];
  logic        m_err;

  typedef struct {
    logic [23:0] w;
    logic [11:0] pc;
    logic        z;
    logic        cy;
    logic [11:0] nxt;
    logic        err;
  } vec_t;

  vec_t tv [12];

  seq_ctrl #(.RESET_PC(12'h000), .STACK_DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .pm_addr  (pm_addr),
    .pm_rd    (pm_rd),
    .pm_data  (pm_data),
    .pm_valid (pm_valid),
    .ir       (ir),
    .exec_en  (exec_en),
    .dp_busy  (dp_busy),
    .flag_z   (flag_z),
    .flag_cy  (flag_cy),
    .stk_err  (stk_err),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; pm_valid = 1'b0; pm_data = '0; dp_busy = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_fetch(input string nm);
    int t;
    t = 0;
    while (!pm_rd && t < 40) begin
      step();
      t++;
    end
    chk(nm, pm_rd, 1);
  endtask

  // One full instruction: fetch (after vdly stalls), decode, exec (busy extra cycles).
  task automatic do_instr(input int vdly, input int busy, output logic [11:0] addr);
    wait_fetch("fetch_wait");
    addr = pm_addr;
    repeat (vdly) begin
      pm_valid = 1'b0;
      pm_data  = 24'h5A5A5A;
      step();
    end
    pm_valid = 1'b1;
    pm_data  = mem[addr];
    step();
    pm_valid = 1'b0;
    pm_data  = '0;
    step();
    dp_busy = 1'b1;
    repeat (busy) step();
    dp_busy = 1'b0;
    step();
  endtask

  // Instruction-level reference: next PC, return stack and sticky error.
  task automatic model_exec(input logic [23:0] w, input logic z, input logic cy);
    logic [11:0] inc, nxt;
    inc = m_pc + 12'd1;
    nxt = inc;
    if (w[23:19] == 5'b10000) begin
      case (w[19:12])
        8'd0: nxt = w[11:0];
        8'd1: if (z)  nxt = w[11:0];
        8'd2: if (!z) nxt = w[11:0];
        8'd3: if (cy) nxt = w[11:0];
        8'd4: if (m_stk.size() > 0) nxt = m_stk.pop_back(); else m_err = 1'b1;
        8'd5: begin
          if (m_stk.size() < 8) m_stk.push_back(inc); else m_err = 1'b1;
          nxt = w[11:0];
        end
        default: nxt = inc;
      endcase
    end
    m_pc = nxt;
  endtask

  function automatic logic [23:0] gen_word();
    int unsigned r;
    logic [11:0] t;
    logic [23:0] w;
    r = $urandom_range(0, 9);
    t = 12'($urandom);
    w = 24'($urandom);
    if (r <= 5)       w = {5'b10000, 7'(r), t};
    else if (r == 6)  w = {5'b10000, 7'($urandom_range(6, 127)), t};
    else if (r == 7)  w = {5'b01000 >> $urandom_range(0, 3), 19'($urandom)};
    return w;
  endfunction

  initial begin
    logic [11:0] a;
    int cnt, acc_cyc;
    bit seen_exec, just_exec;

    flag_z = 1'b0; flag_cy = 1'b0;
    tv[0]  = '{24'h800123, 12'h005, 1'b0, 1'b0, 12'h123, 1'b0};
    tv[1]  = '{24'h801040, 12'h005, 1'b0, 1'b0, 12'h006, 1'b0};
    tv[2]  = '{24'h801040, 12'h005, 1'b1, 1'b0, 12'h040, 1'b0};
    tv[3]  = '{24'h802777, 12'h010, 1'b0, 1'b1, 12'h777, 1'b0};
    tv[4]  = '{24'h802777, 12'h010, 1'b1, 1'b0, 12'h011, 1'b0};
    tv[5]  = '{24'h803ABC, 12'h020, 1'b0, 1'b1, 12'hABC, 1'b0};
    tv[6]  = '{24'h803ABC, 12'h020, 1'b1, 1'b0, 12'h021, 1'b0};
    tv[7]  = '{24'h804000, 12'h007, 1'b0, 1'b0, 12'h008, 1'b1};
    tv[8]  = '{24'h200000, 12'hFFF, 1'b0, 1'b0, 12'h000, 1'b0};
    tv[9]  = '{24'h806123, 12'h030, 1'b1, 1'b1, 12'h031, 1'b0};
    tv[10] = '{24'h18F456, 12'h040, 1'b0, 1'b0, 12'h041, 1'b0};
    tv[11] = '{24'h87F00F, 12'h050, 1'b1, 1'b0, 12'h051, 1'b0};

    // Reset values
    do_reset();
    chk("rst_state", state_o, 0);
    chk("rst_pm_rd", pm_rd, 0);
    chk("rst_exec_en", exec_en, 0);
    chk("rst_ir", ir, 0);
    chk("rst_stk_err", stk_err, 0);
    chk("rst_pc", pm_addr, 12'h000);

    // Back-to-back 3-cycle instructions
    for (int i = 0; i < 3; i++) mem[i] = 24'h200000;
    run = 1'b1;
    pm_valid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      pm_data = mem[pm_addr];
      step();
      chk($sformatf("pipe_exec_%0d", k), exec_en, (k % 3 == 0));
      chk($sformatf("pipe_rd_%0d", k), pm_rd, (k % 3 == 1));
      if (k % 3 == 1) chk($sformatf("pipe_addr_%0d", k), pm_addr, (k - 1) / 3);
    end
    pm_valid = 1'b0;

    // Single-instruction vector table
    for (int i = 0; i < 12; i++) begin
      do_reset();
      run = 1'b1;
      flag_z = tv[i].z;
      flag_cy = tv[i].cy;
      mem[0] = 24'h800000 | {12'h000, tv[i].pc};
      mem[tv[i].pc] = tv[i].w;
      do_instr(0, 0, a);
      do_instr(0, 0, a);
      chk($sformatf("tv%0d_addr", i), a, tv[i].pc);
      wait_fetch($sformatf("tv%0d_wait", i));
      chk($sformatf("tv%0d_next", i), pm_addr, tv[i].nxt);
      chk($sformatf("tv%0d_err", i), stk_err, tv[i].err);
    end

    // dp_busy stretch: flags taken only at release
    do_reset();
    run = 1'b1; flag_z = 1'b0;
    mem[0] = 24'h801040;
    wait_fetch("busy_wait");
    pm_valid = 1'b1; pm_data = mem[0];
    step();
    pm_valid = 1'b0;
    step();
    dp_busy = 1'b1;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (exec_en) cnt++;
      chk($sformatf("busy_state_%0d", c), state_o, (c <= 4) ? 3 : 1);
      if (c == 4) begin dp_busy = 1'b0; flag_z = 1'b1; end
      step();
    end
    chk("busy_exec_cycles", cnt, 5);
    chk("busy_rd", pm_rd, 1);
    chk("busy_next", pm_addr, 12'h040);

    // Delayed pm_valid: request held, ir untouched until accept
    mem[12'h040] = 24'h20ABCD;
    for (int c = 0; c < 3; c++) begin
      pm_valid = 1'b0; pm_data = 24'h123456;
      step();
      chk($sformatf("dly_rd_%0d", c), pm_rd, 1);
      chk($sformatf("dly_ir_%0d", c), ir, 24'h801040);
    end
    pm_valid = 1'b1; pm_data = mem[12'h040];
    step();
    pm_valid = 1'b0;
    chk("dly_ir_acc", ir, 24'h20ABCD);
    chk("dly_state", state_o, 2);

    // BSR then RET
    do_reset();
    run = 1'b1;
    mem[0] = 24'h800010; mem[12'h010] = 24'h805200; mem[12'h200] = 24'h804000;
    do_instr(0, 0, a);
    do_instr(0, 0, a);
    chk("bsr_addr", a, 12'h010);
    do_instr(0, 0, a);
    chk("bsr_target", a, 12'h200);
    wait_fetch("ret_wait");
    chk("ret_next", pm_addr, 12'h011);
    chk("ret_err", stk_err, 0);

    // Nine nested BSRs overflow a depth-8 stack
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 9; i++) mem[i * 16] = 24'h805000 | 24'((i + 1) * 16);
    mem[12'h090] = 24'h804000;
    for (int i = 0; i < 9; i++) begin
      do_instr(0, 0, a);
      chk($sformatf("nest_addr_%0d", i), a, i * 16);
      chk($sformatf("nest_err_%0d", i), stk_err, (i == 8));
    end
    do_instr(0, 0, a);
    chk("nest_9th_target", a, 12'h090);
    wait_fetch("nest_ret_wait");
    chk("nest_ret_next", pm_addr, 12'h071);
    chk("nest_err_sticky", stk_err, 1);

    // Reset during EXEC after a push empties the stack
    do_reset();
    run = 1'b1;
    mem[0] = 24'h805300; mem[12'h300] = 24'h200000;
    do_instr(0, 0, a);
    wait_fetch("rstx_wait");
    pm_valid = 1'b1; pm_data = mem[12'h300];
    step();
    pm_valid = 1'b0;
    step();
    chk("rstx_in_exec", exec_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstx_state", state_o, 0);
    chk("rstx_exec_en", exec_en, 0);
    chk("rstx_pm_rd", pm_rd, 0);
    chk("rstx_pc", pm_addr, 12'h000);
    step();
    rst = 1'b0;
    mem[0] = 24'h804000;
    do_instr(0, 0, a);
    chk("rstx_ret_addr", a, 12'h000);
    wait_fetch("rstx_ret_wait");
    chk("rstx_ret_next", pm_addr, 12'h001);
    chk("rstx_ret_err", stk_err, 1);

    // Reset coincident with pm_valid discards the data
    do_reset();
    run = 1'b1;
    step();
    pm_valid = 1'b1; pm_data = 24'hABCDEF; rst = 1'b1;
    step();
    chk("rstv_ir", ir, 0);
    chk("rstv_state", state_o, 0);
    rst = 1'b0; pm_valid = 1'b0;

    // Randomized programs against the reference model
    do_reset();
    for (int i = 0; i < 4096; i++) mem[i] = gen_word();
    m_pc = 12'h000; m_err = 1'b0; m_stk.delete();
    acc_cyc = -100; seen_exec = 1'b1; run = 1'b1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (pm_rd) chk("rnd_addr", pm_addr, m_pc);
      if (exec_en && !seen_exec) begin
        chk("rnd_latency", cyc - acc_cyc, 2);
        chk("rnd_ir", ir, mem[m_pc]);
        seen_exec = 1'b1;
      end
      flag_z  = 1'($urandom);
      flag_cy = 1'($urandom);
      dp_busy = ($urandom_range(0, 3) == 0);
      run     = ($urandom_range(0, 15) != 0);
      pm_valid = ($urandom_range(0, 2) != 0);
      pm_data  = pm_rd ? mem[pm_addr] : 24'($urandom);
      if (pm_rd && pm_valid) begin
        acc_cyc = cyc;
        seen_exec = 1'b0;
      end
      just_exec = exec_en && !dp_busy;
      if (just_exec) model_exec(mem[m_pc], flag_z, flag_cy);
      step();
      if (just_exec) chk("rnd_stk_err", stk_err, m_err);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Instruction sequencer for the EV22 microprogrammed CPU. Owns the 12-bit program counter and fetches 24-bit instructions from program memory over a valid handshake. Presents each instruction to the microinstruction decoder, waits its one-cycle registered latency, then enables the datapath. Resolves the group-0 control-flow opcodes (JMP/JZE/JNE/JCY/BSR/RET) with a hardware return stack.

## Interface
- `RESET_PC`, default 12'h000: PC value loaded on reset.
- `STACK_DEPTH`, default 8: return-stack entries; power of two, 2..16.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `run` in 1: sequencer runs while high; when low, it finishes the current instruction and parks in IDLE.
- `pm_addr` out 12: program memory address (= PC during FETCH).
- `pm_rd` out 1: read request, held until accepted.
- `pm_data` in 24: instruction word.
- `pm_valid` in 1: `pm_data` valid; accepted in any cycle where `pm_rd`=1.
- `ir` out 24: latched instruction, drives decoder IR input.
- `exec_en` out 1: datapath may act on the current microinstruction.
- `dp_busy` in 1: datapath extends execution (MOM memory access etc.).
- `flag_z`, `flag_cy` in 1 each: datapath zero/carry flags.
- `stk_err` out 1: sticky; return-stack overflow or underflow occurred.
- `state_o` out 2: current state, for debug.

## Operation
- States: IDLE(0), FETCH(1), DECODE(2), EXEC(3).
- IDLE: `run`=1 -> FETCH next cycle.
- FETCH: `pm_rd`=1, `pm_addr`=PC. On `pm_valid`=1, `ir`<=`pm_data` and go to DECODE. With no valid, stay in FETCH indefinitely.
- DECODE: one cycle, no outputs asserted. This cycle covers the decoder's registered latency. Go to EXEC.
- EXEC: `exec_en`=1. Stay while `dp_busy`=1. On the first EXEC cycle with `dp_busy`=0, update PC, then go to FETCH if `run`=1, else IDLE.
- Group 0 is `ir[23:19]`=5'b10000. The opcode is `ir[19:12]`; the target is `ir[11:0]`. PC update is resolved with the flags sampled in the final EXEC cycle:
  - op 0 JMP: PC<=target.
  - op 1 JZE: `flag_z` ? target : PC+1.
  - op 2 JNE: `!flag_z` ? target : PC+1.
  - op 3 JCY: `flag_cy` ? target : PC+1.
  - op 4 RET: PC<=pop.
  - op 5 BSR: push PC+1, PC<=target.
  - ops 6..255 (MOM etc.) and all other groups, including unrecognised group codes: PC<=PC+1.
- Arithmetic: PC+1 is modulo 4096, so 12'hFFF wraps to 12'h000.
- Return stack, LIFO of `STACK_DEPTH` x 12 bits:
  - BSR when full: the push is dropped, `stk_err`<=1, and the jump is still taken.
  - RET when empty: `stk_err`<=1 and PC<=PC+1.
- `stk_err` clears only on reset.
- `run` falling mid-fetch/decode has no effect until EXEC completes.

## Timing
- Reset values: state=IDLE, PC=`RESET_PC`, `ir`=24'h000000 (decodes as NOP default), `pm_rd`=0, `exec_en`=0, `stk_err`=0, stack empty.
- Minimum instruction period is 3 cycles: FETCH with `pm_valid` in the same cycle, then DECODE, then EXEC with `dp_busy`=0.
- `pm_addr` for the next instruction is valid the cycle after the final EXEC cycle.
- `exec_en` deasserts the cycle the state leaves EXEC.
- `rst` asserted in any state aborts immediately: an outstanding `pm_rd` drops, a pending push/pop is lost, and the stack is emptied.
- Simultaneous `pm_valid` and `rst`: reset wins and the data is discarded.

## Structure
- Package `ev22_pkg` holds:
  - the `seq_state_t` enum;
  - group one-hot constants (GRP0 = 5'b10000 .. GRP4 = 5'b00001);
  - group-0 opcode localparams OP_JMP..OP_BSR;
  - the PC width constant 12.
- One sub-module, `ret_stack`: parameterised depth, `push`/`pop`/`din`/`dout`/`full`/`empty`, with `rst` asynchronous active-high. Its pointer saturates and never wraps.
- Next-PC logic stays combinational inside `seq_ctrl`.

## Test plan
- Reset then `run`=1, memory returns 24'h200000 at 0 with `pm_valid` same cycle -> `pm_addr` sequence 0,1,2; `exec_en` every 3rd cycle.
- JMP 24'h800123 at PC 5 -> next `pm_addr`=12'h123. JZE 24'h801040 with `flag_z`=0 -> next 6; with `flag_z`=1 -> 12'h040.
- BSR 24'h805200 at 12'h010, then RET at 12'h200 -> fetch 12'h200, then 12'h011. Nine nested BSRs (depth 8) -> `stk_err`=1 after the 9th, and the 9th target is still fetched.
- RET on empty stack at PC 7 -> `stk_err`=1, next fetch 8. Instruction at 12'hFFF non-branch -> next fetch 12'h000.
- `dp_busy` held 4 cycles in EXEC -> `exec_en` high 5 cycles, PC unchanged until release. `pm_valid` delayed 3 cycles -> `pm_rd` held, `ir` unchanged until accept.
- `rst` pulsed during EXEC after a pushed BSR -> state IDLE, PC=`RESET_PC`, stack empty (a following RET sets `stk_err`).
